// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller.
//   state_t    : frame sequencer states (binary, 3 bits)
//   PAR_EVEN / PAR_ODD    : PAR_TYP encodings
//   LINE_IDLE / START_BIT : TX line levels
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for the UART transmit path.
// Ports:
//   data     in  DATA_WIDTH  byte being framed
//   par_typ  in  1           0 = even, 1 = odd
//   par_bit  out 1           parity bit to place on the line
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity is the plain XOR reduction; odd parity inverts it.
  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller. Sequences start, data (from the serializer,
// LSB first), optional parity and stop bits onto the TX line, one bit per clock.
// Ports:
//   CLK         in   1           clock, rising edge
//   RST         in   1           asynchronous reset, active low
//   P_DATA      in   DATA_WIDTH  byte to send (used here only for parity)
//   DATA_VALID  in   1           frame request, accepted only in IDLE
//   PAR_EN      in   1           insert parity bit
//   PAR_TYP     in   1           0 = even, 1 = odd
//   SER_DONE    in   1           serializer presenting its last data bit
//   SER_DATA    in   1           current serializer data bit
//   SER_ENABLE  out  1           serializer shift/count enable
//   BUSY        out  1           frame in progress
//   TX_OUT      out  1           serial line, idle high
//
// state  | meaning
// IDLE   | line high, waiting for DATA_VALID
// START  | start bit (line low), serializer holds its first bit
// DATA   | line follows SER_DATA until SER_DONE
// PARITY | latched parity bit on the line
// STOP   | stop bit (line high), last busy cycle
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  SER_DONE,
  input  logic                  SER_DATA,
  output logic                  SER_ENABLE,
  output logic                  BUSY,
  output logic                  TX_OUT
);

  state_t state;
  logic   par_calc;
  logic   par_bit;
  logic   par_en_q;
  logic   busy_q;
  logic   ser_en_q;
  logic   tx_level;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );

  // Outputs are registered alongside the state so each one always equals the
  // decode of the current state; reset clears them together with the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      busy_q   <= 1'b0;
      ser_en_q <= 1'b0;
      tx_level <= LINE_IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            state    <= START;
            par_bit  <= par_calc;
            par_en_q <= PAR_EN;
            busy_q   <= 1'b1;
            ser_en_q <= 1'b0;
            tx_level <= START_BIT;
          end
        end
        START: begin
          state    <= DATA;
          busy_q   <= 1'b1;
          ser_en_q <= 1'b1;
          tx_level <= LINE_IDLE;
        end
        DATA: begin
          if (SER_DONE) begin
            // Dropping the enable here lets the serializer counter clear.
            ser_en_q <= 1'b0;
            if (par_en_q) begin
              state    <= PARITY;
              tx_level <= par_bit;
            end else begin
              state    <= STOP;
              tx_level <= LINE_IDLE;
            end
          end
        end
        PARITY: begin
          state    <= STOP;
          tx_level <= LINE_IDLE;
        end
        STOP: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          tx_level <= LINE_IDLE;
        end
        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          ser_en_q <= 1'b0;
          tx_level <= LINE_IDLE;
        end
      endcase
    end
  end

  assign BUSY       = busy_q;
  assign SER_ENABLE = ser_en_q;
  // In DATA the line is driven straight from the serializer bit.
  assign TX_OUT     = (state == DATA) ? SER_DATA : tx_level;

endmodule
